// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core: owns the PC and register file and steps each
// instruction through FETCH/DECODE/EXEC/[MEM]/WB over req/ack memory ports.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FETCH  | imem_req high at pc; latch the instruction word on imem_ack
// S_DECODE | legality check, read rs1/rs2, build the immediate
// S_EXEC   | ALU / branch / address; misaligned target or access traps
// S_MEM    | dmem_req high with stable outputs until dmem_ack
// S_WB     | write rd, pc <= next_pc, one-cycle retire pulse
// S_TRAP   | absorbing; no requests, pc frozen at the faulting instruction
module multicycle_core #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN/8-1:0] dmem_wstrb,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              retire,
    output logic [XLEN-1:0]   pc,
    output logic              trap
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int SHW  = $clog2(XLEN);
    localparam int RIDX = $clog2(NREGS);
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] rs1_val_q, rs1_val_d;
    logic [XLEN-1:0] rs2_val_q, rs2_val_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] npc_q, npc_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    logic [XLEN-1:0] regs_q [NREGS];

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic is_op, is_opimm, is_load, is_store, is_branch, is_lui, is_jal;
    logic writes_rd;

    assign opcode    = instr_q[6:0];
    assign rd        = instr_q[11:7];
    assign f3        = instr_q[14:12];
    assign rs1       = instr_q[19:15];
    assign rs2       = instr_q[24:20];
    assign f7        = instr_q[31:25];
    assign is_op     = (opcode == OPC_OP);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_jal    = (opcode == OPC_JAL);
    assign writes_rd = is_op | is_opimm | is_load | is_lui | is_jal;

    // Decode legality, register-index range check and immediate formation.
    logic            legal, uses_rs1, uses_rs2, uses_rd, bad_idx;
    logic [XLEN-1:0] imm_dec;
    always_comb begin
        legal    = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        uses_rd  = 1'b0;
        imm_dec  = '0;
        case (opcode)
            OPC_OPIMM: begin
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
                imm_dec  = sext32({{20{instr_q[31]}}, instr_q[31:20]});
                if (f3 == 3'b001)
                    legal = (instr_q[31:20+SHW] == '0);
                else if (f3 == 3'b101)
                    legal = !instr_q[31] && (instr_q[29:20+SHW] == '0);
                else
                    legal = 1'b1;
            end
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                uses_rd  = 1'b1;
                legal    = (f7 == 7'b0000000) ||
                           (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            end
            OPC_LOAD: begin
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
                imm_dec  = sext32({{20{instr_q[31]}}, instr_q[31:20]});
                legal    = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                           (f3 == 3'b100) || (f3 == 3'b101);
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_dec  = sext32({{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]});
                legal    = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_dec  = sext32({{19{instr_q[31]}}, instr_q[31], instr_q[7],
                                   instr_q[30:25], instr_q[11:8], 1'b0});
                legal    = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OPC_LUI: begin
                uses_rd = 1'b1;
                imm_dec = sext32({instr_q[31:12], 12'b0});
                legal   = 1'b1;
            end
            OPC_JAL: begin
                uses_rd = 1'b1;
                imm_dec = sext32({{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                                  instr_q[20], instr_q[30:21], 1'b0});
                legal   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        bad_idx = (uses_rs1 && ({1'b0, rs1} >= NREGS_W)) ||
                  (uses_rs2 && ({1'b0, rs2} >= NREGS_W)) ||
                  (uses_rd  && ({1'b0, rd}  >= NREGS_W));
    end

    // Execute datapath: ALU, branch resolution, effective address.
    logic [XLEN-1:0] op_b, alu, pc_plus4, target, maddr_calc, exec_res;
    logic [SHW-1:0]  shamt;
    logic            alt, cond, taken, misalign;
    always_comb begin
        op_b       = is_op ? rs2_val_q : imm_q;
        shamt      = op_b[SHW-1:0];
        alt        = is_op ? instr_q[30] : (f3 == 3'b101 && instr_q[30]);
        alu        = '0;
        case (f3)
            3'b000:  alu = (is_op && alt) ? rs1_val_q - op_b : rs1_val_q + op_b;
            3'b001:  alu = rs1_val_q << shamt;
            3'b010:  alu = {{(XLEN-1){1'b0}}, $signed(rs1_val_q) < $signed(op_b)};
            3'b011:  alu = {{(XLEN-1){1'b0}}, rs1_val_q < op_b};
            3'b100:  alu = rs1_val_q ^ op_b;
            3'b101:  alu = alt ? XLEN'($signed(rs1_val_q) >>> shamt) : rs1_val_q >> shamt;
            3'b110:  alu = rs1_val_q | op_b;
            default: alu = rs1_val_q & op_b;
        endcase
        case (f3)
            3'b000:  cond = (rs1_val_q == rs2_val_q);
            3'b001:  cond = (rs1_val_q != rs2_val_q);
            3'b100:  cond = ($signed(rs1_val_q) <  $signed(rs2_val_q));
            3'b101:  cond = ($signed(rs1_val_q) >= $signed(rs2_val_q));
            3'b110:  cond = (rs1_val_q <  rs2_val_q);
            default: cond = (rs1_val_q >= rs2_val_q);
        endcase
        pc_plus4   = pc_q + XLEN'(4);
        target     = pc_q + imm_q;
        taken      = is_jal || (is_branch && cond);
        maddr_calc = rs1_val_q + imm_q;
        misalign   = (f3[1:0] == 2'b01 && maddr_calc[0]) ||
                     (f3[1:0] == 2'b10 && maddr_calc[1:0] != 2'b00);
        exec_res   = is_lui ? imm_q : (is_jal ? pc_plus4 : alu);
    end

    // Memory lane steering for stores and sub-word load extraction.
    logic [OFFW-1:0] off;
    logic [NB-1:0]   strb_base;
    logic [XLEN-1:0] ld_shift, ld_val;
    always_comb begin
        off = maddr_q[OFFW-1:0];
        case (f3[1:0])
            2'b00:   strb_base = NB'(1);
            2'b01:   strb_base = NB'(3);
            default: strb_base = NB'(15);
        endcase
        ld_shift = dmem_rdata >> {off, 3'b000};
        case (f3)
            3'b000:  ld_val = XLEN'($signed(ld_shift[7:0]));
            3'b001:  ld_val = XLEN'($signed(ld_shift[15:0]));
            3'b010:  ld_val = XLEN'($signed(ld_shift[31:0]));
            3'b100:  ld_val = XLEN'(ld_shift[7:0]);
            default: ld_val = XLEN'(ld_shift[15:0]);
        endcase
    end

    // Next-state logic and per-state register updates.
    logic rf_we;
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        imm_d     = imm_q;
        res_d     = res_q;
        npc_d     = npc_q;
        maddr_d   = maddr_q;
        rf_we     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal || bad_idx) begin
                    state_d = S_TRAP;
                end else begin
                    rs1_val_d = regs_q[rs1[RIDX-1:0]];
                    rs2_val_d = regs_q[rs2[RIDX-1:0]];
                    imm_d     = imm_dec;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = exec_res;
                npc_d   = taken ? target : pc_plus4;
                maddr_d = maddr_calc;
                if (taken && target[1:0] != 2'b00)
                    state_d = S_TRAP;
                else if (is_load || is_store)
                    state_d = misalign ? S_TRAP : S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (is_load)
                        res_d = ld_val;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we   = writes_rd && (rd != 5'd0);
                pc_d    = npc_q;
                state_d = S_FETCH;
            end
            default: state_d = S_TRAP;
        endcase
    end

    // Control and datapath registers; reset overrides any pending handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
            res_q     <= '0;
            npc_q     <= '0;
            maddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            imm_q     <= imm_d;
            res_q     <= res_d;
            npc_q     <= npc_d;
            maddr_q   <= maddr_d;
        end
    end

    // Register file; x0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (rf_we) begin
            regs_q[rd[RIDX-1:0]] <= res_q;
        end
    end

    assign imem_req   = (state_q == S_FETCH) && !rst;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = (state_q == S_MEM) && is_store;
    assign dmem_addr  = maddr_q & ~XLEN'(NB - 1);
    assign dmem_wdata = rs2_val_q << {off, 3'b000};
    assign dmem_wstrb = ((state_q == S_MEM) && is_store) ? (strb_base << off) : '0;
    assign retire     = (state_q == S_WB);
    assign pc         = pc_q;
    assign trap       = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: stimulus pushes expected fetches,
// data accesses and retirements; a negedge monitor pops and compares them.
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        retire, trap;
    logic [31:0] pc;

    always #5 clk = ~clk;

    multicycle_core #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .retire(retire), .pc(pc), .trap(trap)
    );

    typedef struct { logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; } dexp_t;
    typedef struct { logic [31:0] pc; int lat; } rexp_t;

    logic [31:0] fetch_q[$];
    dexp_t       dmem_q[$];
    rexp_t       ret_q[$];
    logic [31:0] imem_mem [64];
    int          imem_wait = 0;
    int          dmem_wait = 0;
    logic [31:0] load_word = 32'h8000_0000;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [12:0] b;
        b = 13'(imm);
        return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'(f3), b[4:1], b[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] j;
        j = 21'(imm);
        return {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'b1101111};
    endfunction

    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] LOAD  = 7'b0000011;

    task automatic exp_ret(input logic [31:0] p, input int lat);
        rexp_t r;
        r.pc = p; r.lat = lat;
        fetch_q.push_back(p);
        ret_q.push_back(r);
    endtask
    task automatic exp_mem(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        dexp_t e;
        e.we = we; e.addr = a; e.strb = s; e.wdata = d;
        dmem_q.push_back(e);
    endtask

    // Memory responder: acks after the configured number of wait cycles.
    initial begin
        int ic, dc;
        ic = 0; dc = 0;
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (imem_req) begin
                if (ic >= imem_wait) begin
                    imem_ack = 1'b1; imem_rdata = imem_mem[imem_addr[7:2]]; ic = 0;
                end else ic++;
            end else ic = 0;
            if (dmem_req) begin
                if (dc >= dmem_wait) begin
                    dmem_ack = 1'b1; dmem_rdata = load_word; dc = 0;
                end else dc++;
            end else dc = 0;
        end
    end

    // Monitor: compares every new request and retirement against the queues.
    initial begin
        int cnt;
        logic pi, pd;
        logic [31:0] h_iaddr, h_daddr, h_wdata;
        logic [3:0] h_strb;
        logic h_we;
        dexp_t e;
        rexp_t r;
        cnt = 0; pi = 1'b0; pd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0; pi = 1'b0; pd = 1'b0;
            end else begin
                cnt++;
                check("req_exclusive", {31'b0, imem_req & dmem_req}, 32'd0);
                if (imem_req && !pi) begin
                    check("fetch_expected", fetch_q.size(), 1 + (fetch_q.size() > 1 ? fetch_q.size() - 1 : 0));
                    if (fetch_q.size() > 0) check("imem_addr", imem_addr, fetch_q.pop_front());
                    h_iaddr = imem_addr;
                end else if (imem_req) begin
                    check("imem_addr_stable", imem_addr, h_iaddr);
                end
                if (dmem_req && !pd) begin
                    check("dmem_expected", dmem_q.size(), 1 + (dmem_q.size() > 1 ? dmem_q.size() - 1 : 0));
                    if (dmem_q.size() > 0) begin
                        e = dmem_q.pop_front();
                        check("dmem_we", {31'b0, dmem_we}, {31'b0, e.we});
                        check("dmem_addr", dmem_addr, e.addr);
                        check("dmem_wstrb", {28'b0, dmem_wstrb}, {28'b0, e.strb});
                        if (e.we) check("dmem_wdata", dmem_wdata, e.wdata);
                    end
                    h_daddr = dmem_addr; h_wdata = dmem_wdata; h_strb = dmem_wstrb; h_we = dmem_we;
                end else if (dmem_req) begin
                    check("dmem_addr_stable", dmem_addr, h_daddr);
                    check("dmem_wdata_stable", dmem_wdata, h_wdata);
                    check("dmem_ctl_stable", {27'b0, dmem_we, dmem_wstrb}, {27'b0, h_we, h_strb});
                end
                if (retire) begin
                    check("retire_expected", ret_q.size(), 1 + (ret_q.size() > 1 ? ret_q.size() - 1 : 0));
                    if (ret_q.size() > 0) begin
                        r = ret_q.pop_front();
                        check("retire_pc", pc, r.pc);
                        check("retire_latency", cnt, r.lat);
                    end
                    cnt = 0;
                end
                pi = imem_req;
                pd = dmem_req;
            end
        end
    end

    task automatic begin_reset();
        rst = 1'b1;
        fetch_q.delete(); dmem_q.delete(); ret_q.delete();
        for (int i = 0; i < 64; i++) imem_mem[i] = 32'h0;
    endtask

    task automatic end_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_dmem", {26'b0, dmem_req, dmem_we, dmem_wstrb}, 32'd0);
        check("rst_retire", {31'b0, retire}, 32'd0);
        check("rst_trap", {31'b0, trap}, 32'd0);
        check("rst_pc", imem_addr, 32'h0);
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((ret_q.size() + dmem_q.size() + fetch_q.size()) != 0 && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check("section_complete", ret_q.size() + dmem_q.size() + fetch_q.size(), 32'd0);
    endtask

    task automatic wait_trap(input logic [31:0] exp_pc);
        int n;
        n = 0;
        while (!trap && n < 100) begin @(negedge clk); #1; n++; end
        check("trap_set", {31'b0, trap}, 32'd1);
        check("trap_pc", pc, exp_pc);
        repeat (20) @(negedge clk);
        #1;
        check("trap_sticky", {31'b0, trap}, 32'd1);
        check("trap_pc_frozen", pc, exp_pc);
        check("trap_no_more", ret_q.size() + dmem_q.size() + fetch_q.size(), 32'd0);
    endtask

    initial begin
        // Run A: ALU, stores, loads, branches, JAL with zero-wait memory.
        begin_reset();
        imem_mem[0]  = enc_i(5, 0, 0, 1, OPIMM);             // x1 = 5
        imem_mem[1]  = enc_r(7'h00, 1, 1, 0, 2);              // x2 = 10
        imem_mem[2]  = enc_r(7'h20, 1, 0, 0, 3);              // x3 = 0 - 5
        imem_mem[3]  = enc_s(32'h200, 3, 0, 2);               // SW x3
        imem_mem[4]  = enc_i(32'h103, 0, 0, 4, OPIMM);        // x4 = 0x103
        imem_mem[5]  = enc_s(0, 2, 4, 0);                     // SB x2 -> 0x103
        imem_mem[6]  = enc_b(12, 0, 8, 1);                    // 0x18 BNE x8,x0,+12
        imem_mem[7]  = enc_i(1, 0, 0, 8, OPIMM);              // x8 = 1
        imem_mem[8]  = enc_b(-8, 1, 1, 0);                    // 0x20 BEQ x1,x1,-8
        imem_mem[9]  = enc_i(0, 4, 0, 9, LOAD);               // LB x9
        imem_mem[10] = enc_i(0, 4, 4, 10, LOAD);              // LBU x10
        imem_mem[11] = enc_s(32'h204, 9, 0, 2);               // SW x9
        imem_mem[12] = enc_j(16, 5);                          // 0x30 JAL x5,+16
        imem_mem[16] = enc_s(32'h208, 10, 0, 2);              // SW x10
        imem_mem[17] = enc_s(32'h20C, 5, 0, 2);               // SW x5
        imem_mem[18] = enc_i(32'h401, 3, 5, 12, OPIMM);       // SRAI x12,x3,1
        imem_mem[19] = enc_r(7'h00, 3, 1, 3, 13);             // SLTU x13,x1,x3
        imem_mem[20] = enc_r(7'h00, 12, 13, 0, 13);           // x13 = x13 + x12
        imem_mem[21] = enc_s(32'h212, 13, 0, 1);              // SH x13 -> 0x212
        exp_ret(32'h00, 4); exp_ret(32'h04, 4); exp_ret(32'h08, 4);
        exp_ret(32'h0C, 5); exp_mem(1'b1, 32'h200, 4'b1111, 32'hFFFF_FFFB);
        exp_ret(32'h10, 4);
        exp_ret(32'h14, 5); exp_mem(1'b1, 32'h100, 4'b1000, 32'h0A00_0000);
        exp_ret(32'h18, 4); exp_ret(32'h1C, 4); exp_ret(32'h20, 4); exp_ret(32'h18, 4);
        exp_ret(32'h24, 5); exp_mem(1'b0, 32'h100, 4'b0000, 32'h0);
        exp_ret(32'h28, 5); exp_mem(1'b0, 32'h100, 4'b0000, 32'h0);
        exp_ret(32'h2C, 5); exp_mem(1'b1, 32'h204, 4'b1111, 32'hFFFF_FF80);
        exp_ret(32'h30, 4);
        exp_ret(32'h40, 5); exp_mem(1'b1, 32'h208, 4'b1111, 32'h0000_0080);
        exp_ret(32'h44, 5); exp_mem(1'b1, 32'h20C, 4'b1111, 32'h0000_0034);
        exp_ret(32'h48, 4); exp_ret(32'h4C, 4); exp_ret(32'h50, 4);
        exp_ret(32'h54, 5); exp_mem(1'b1, 32'h210, 4'b1100, 32'hFFFE_0000);
        end_reset();
        wait_done(400);
        check("run_a_no_trap", {31'b0, trap}, 32'd0);

        // Run B: slow memories, LW then SW of the loaded value.
        begin_reset();
        imem_wait = 3; dmem_wait = 2;
        imem_mem[0] = enc_i(32'h104, 0, 2, 11, LOAD);
        imem_mem[1] = enc_s(32'h210, 11, 0, 2);
        exp_ret(32'h00, 10); exp_mem(1'b0, 32'h104, 4'b0000, 32'h0);
        exp_ret(32'h04, 10); exp_mem(1'b1, 32'h210, 4'b1111, 32'h8000_0000);
        end_reset();
        wait_done(200);

        // Run C: illegal opcode after one good instruction.
        begin_reset();
        imem_wait = 0; dmem_wait = 0;
        imem_mem[0] = enc_i(1, 0, 0, 1, OPIMM);
        imem_mem[1] = 32'h0000_007F;
        exp_ret(32'h00, 4);
        fetch_q.push_back(32'h04);
        end_reset();
        wait_trap(32'h04);

        // Run D: misaligned LW traps without a data request.
        begin_reset();
        imem_mem[0] = enc_i(32'h102, 0, 2, 1, LOAD);
        fetch_q.push_back(32'h00);
        end_reset();
        wait_trap(32'h00);

        begin_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_clears_trap", {31'b0, trap}, 32'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
